// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - 8-channel TDM demultiplexer with frame-sync tracking
// Collects one sample per valid cycle into shadow slots and publishes all 8 channels on channel 7.
module tdm_demux8 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_sync,
  output logic [8*W-1:0] dout,
  output logic           frame_valid,
  output logic           locked,
  output logic [2:0]     ch_idx,
  output logic           sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [2:0]     cnt, cnt_nxt;
  logic [W-1:0]   sh     [0:6];
  logic [W-1:0]   sh_nxt [0:6];
  logic [8*W-1:0] dout_nxt;
  logic           frame_valid_nxt;
  logic           sync_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      cnt         <= 3'd0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      for (int k = 0; k < 7; k++) sh[k] <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      dout        <= dout_nxt;
      frame_valid <= frame_valid_nxt;
      sync_err    <= sync_err_nxt;
      for (int k = 0; k < 7; k++) sh[k] <= sh_nxt[k];
    end
  end

  // A sync always restarts the frame at slot 1; a non-sync at slot 0 means alignment was lost.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            state_nxt = LOCKED;
            cnt_nxt   = 3'd1;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            cnt_nxt = 3'd1;
          end else if (cnt == 3'd0) begin
            state_nxt = HUNT;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
        default: begin
          state_nxt = HUNT;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 7; k++) sh_nxt[k] = sh[k];
    dout_nxt        = dout;
    frame_valid_nxt = 1'b0;
    sync_err_nxt    = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) sh_nxt[0] = din;
        end
        LOCKED: begin
          if (frame_sync) begin
            sh_nxt[0]    = din;
            sync_err_nxt = (cnt != 3'd0);
          end else if (cnt == 3'd0) begin
            sync_err_nxt = 1'b1;
          end else if (cnt == 3'd7) begin
            for (int k = 0; k < 7; k++) dout_nxt[k*W +: W] = sh[k];
            dout_nxt[7*W +: W] = din;
            frame_valid_nxt    = 1'b1;
          end else begin
            for (int k = 1; k < 7; k++) begin
              if (cnt == 3'(k)) sh_nxt[k] = din;
            end
          end
        end
        default: begin
          sync_err_nxt = 1'b0;
        end
      endcase
    end
  end

  assign locked = (state == LOCKED);
  assign ch_idx = cnt;

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - self-checking bench for tdm_demux8 (W=1 and W=4 instances)
// A sample-list reference model predicts every output after each clock edge.
module tb_tdm_demux8;

  logic        clk;
  logic        rst;
  logic        din1, v1, s1;
  logic [7:0]  dout1;
  logic        fv1, lk1, se1;
  logic [2:0]  ci1;
  logic [3:0]  din4;
  logic        v4, s4;
  logic [31:0] dout4;
  logic        fv4, lk4, se4;
  logic [2:0]  ci4;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int fvc [2];
  int erc [2];
  int fv4_cycles [$];

  bit          m_lk   [2];
  int          m_n    [2];
  logic [3:0]  m_buf  [2][8];
  logic [31:0] m_dout [2];
  bit          m_fv   [2];
  bit          m_err  [2];

  tdm_demux8 #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .frame_sync(s1),
    .dout(dout1), .frame_valid(fv1), .locked(lk1), .ch_idx(ci1), .sync_err(se1)
  );

  tdm_demux8 #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(v4), .frame_sync(s4),
    .dout(dout4), .frame_valid(fv4), .locked(lk4), .ch_idx(ci4), .sync_err(se4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a frame is a list of samples started by a sync; eight samples make a publish.
  task automatic model_step(input int i, input logic [3:0] d, input bit v, input bit s);
    int wd;
    wd = (i == 0) ? 1 : 4;
    m_fv[i]  = 0;
    m_err[i] = 0;
    if (rst) begin
      m_lk[i] = 0; m_n[i] = 0; m_dout[i] = 0;
      return;
    end
    if (!v) return;
    if (!m_lk[i]) begin
      if (s) begin m_lk[i] = 1; m_buf[i][0] = d; m_n[i] = 1; end
    end else if (s) begin
      if (m_n[i] != 0) m_err[i] = 1;
      m_buf[i][0] = d;
      m_n[i] = 1;
    end else if (m_n[i] == 0) begin
      m_err[i] = 1;
      m_lk[i]  = 0;
    end else begin
      m_buf[i][m_n[i]] = d;
      m_n[i]++;
      if (m_n[i] == 8) begin
        m_dout[i] = 0;
        for (int k = 0; k < 8; k++) m_dout[i] = m_dout[i] + (32'(m_buf[i][k]) << (k * wd));
        m_fv[i] = 1;
        m_n[i]  = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(0, {3'b000, din1}, v1, s1);
    model_step(1, din4, v4, s4);
    @(negedge clk);
    chk("dout1", {24'd0, dout1}, m_dout[0]);
    chk("fv1",   {31'd0, fv1},   {31'd0, m_fv[0]});
    chk("lk1",   {31'd0, lk1},   {31'd0, m_lk[0]});
    chk("ci1",   {29'd0, ci1},   32'(m_n[0]));
    chk("se1",   {31'd0, se1},   {31'd0, m_err[0]});
    chk("dout4", dout4,          m_dout[1]);
    chk("fv4",   {31'd0, fv4},   {31'd0, m_fv[1]});
    chk("lk4",   {31'd0, lk4},   {31'd0, m_lk[1]});
    chk("ci4",   {29'd0, ci4},   32'(m_n[1]));
    chk("se4",   {31'd0, se4},   {31'd0, m_err[1]});
    if (fv1) fvc[0]++;
    if (se1) erc[0]++;
    if (fv4) begin fvc[1]++; fv4_cycles.push_back(cyc); end
    if (se4) erc[1]++;
  endtask

  task automatic idle(input int n);
    v1 = 0; s1 = 0; v4 = 0; s4 = 0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic smp(input int i, input logic [3:0] d, input bit s);
    v1 = 0; s1 = 0; v4 = 0; s4 = 0;
    if (i == 0) begin din1 = d[0]; v1 = 1; s1 = s; end
    else begin din4 = d; v4 = 1; s4 = s; end
    tick();
  endtask

  task automatic send_frame(input int i, input logic [31:0] val, input bit gaps);
    for (int k = 0; k < 8; k++) begin
      if (gaps) idle(int'($urandom_range(0, 2)));
      if (i == 0) smp(0, {3'b000, val[k]}, k == 0);
      else smp(1, val[k*4 +: 4], k == 0);
    end
  endtask

  task automatic do_reset();
    rst = 1; v1 = 0; s1 = 0; v4 = 0; s4 = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    int f0, e0;
    rst = 0; din1 = 0; v1 = 0; s1 = 0; din4 = 0; v4 = 0; s4 = 0;
    fvc[0] = 0; fvc[1] = 0; erc[0] = 0; erc[1] = 0;
    for (int i = 0; i < 2; i++) begin m_lk[i] = 0; m_n[i] = 0; m_dout[i] = 0; end

    do_reset();
    chk("rst_dout1", {24'd0, dout1}, 32'd0);
    chk("rst_lk1",   {31'd0, lk1},   32'd0);
    chk("rst_ci4",   {29'd0, ci4},   32'd0);

    // Basic frame
    send_frame(0, 32'hB3, 0);
    chk("basic_dout", {24'd0, dout1}, 32'hB3);
    chk("basic_fv",   {31'd0, fv1},   32'd1);
    chk("basic_lk",   {31'd0, lk1},   32'd1);
    chk("basic_ci",   {29'd0, ci1},   32'd0);
    idle(1);
    chk("basic_fv_drop", {31'd0, fv1}, 32'd0);

    // Hunt discard and gaps
    do_reset();
    for (int k = 0; k < 3; k++) begin
      smp(0, 4'($urandom_range(0, 1)), 0);
      chk("hunt_lk", {31'd0, lk1}, 32'd0);
      chk("hunt_ci", {29'd0, ci1}, 32'd0);
    end
    f0 = fvc[0]; e0 = erc[0];
    send_frame(0, 32'hD5, 1);
    idle(2);
    chk("hunt_dout", {24'd0, dout1}, 32'hD5);
    chk("hunt_fvc",  32'(fvc[0] - f0), 32'd1);
    chk("hunt_erc",  32'(erc[0] - e0), 32'd0);

    // Early sync
    send_frame(0, 32'hB3, 0);
    f0 = fvc[0]; e0 = erc[0];
    for (int k = 0; k < 4; k++) smp(0, 4'($urandom_range(0, 1)), k == 0);
    for (int k = 0; k < 7; k++) begin
      smp(0, {3'b000, k < 4}, k == 0);
      chk("early_hold", {24'd0, dout1}, 32'hB3);
    end
    smp(0, 4'd0, 0);
    chk("early_dout", {24'd0, dout1}, 32'h0F);
    chk("early_fvc",  32'(fvc[0] - f0), 32'd1);
    chk("early_erc",  32'(erc[0] - e0), 32'd1);

    // Missing sync
    send_frame(0, 32'h5A, 1);
    f0 = fvc[0];
    smp(0, 4'd1, 0);
    chk("miss_se", {31'd0, se1}, 32'd1);
    chk("miss_lk", {31'd0, lk1}, 32'd0);
    for (int k = 0; k < 9; k++) begin
      smp(0, 4'($urandom_range(0, 1)), 0);
      chk("miss_ignored", {31'd0, lk1}, 32'd0);
    end
    chk("miss_fvc",  32'(fvc[0] - f0), 32'd0);
    chk("miss_dout", {24'd0, dout1}, 32'h5A);

    // W=4 back-to-back
    do_reset();
    fv4_cycles.delete();
    send_frame(1, 32'h76543210, 0);
    chk("w4_dout_a", dout4, 32'h76543210);
    send_frame(1, 32'h89ABCDEF, 0);
    chk("w4_dout_b", dout4, 32'h89ABCDEF);
    chk("w4_npulse", 32'(fv4_cycles.size()), 32'd2);
    if (fv4_cycles.size() == 2) chk("w4_spacing", 32'(fv4_cycles[1] - fv4_cycles[0]), 32'd8);

    // Reset mid-frame
    for (int k = 0; k < 4; k++) smp(0, 4'd1, k == 0);
    do_reset();
    chk("mid_dout1", {24'd0, dout1}, 32'd0);
    chk("mid_dout4", dout4, 32'd0);
    chk("mid_lk",    {31'd0, lk1}, 32'd0);
    chk("mid_ci",    {29'd0, ci1}, 32'd0);
    send_frame(0, 32'hA5, 1);
    chk("mid_a5", {24'd0, dout1}, 32'hA5);

    // Random traffic on both instances
    for (int n = 0; n < 600; n++) begin
      din1 = 1'($urandom_range(0, 1));
      v1   = ($urandom_range(0, 3) != 0);
      s1   = ($urandom_range(0, 7) == 0);
      din4 = 4'($urandom_range(0, 15));
      v4   = ($urandom_range(0, 3) != 0);
      s4   = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Time-division demultiplexer: the receive-side counterpart of the 8:1 select muxes. A multiplexed sample stream arrives one channel per valid cycle, with channel 0 flagged by `frame_sync`. The block tracks frame alignment, steers each sample into its channel slot, and publishes all 8 channels atomically once a frame completes. It sits after the serial/TDM link and before per-channel consumers.

## Interface
- `W`, default 1: sample width per channel, in bits.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `din`  input  W  muxed sample for the current channel slot.
- `din_valid`  input  1  `din` carries a sample this cycle.
- `frame_sync`  input  1  qualified by `din_valid`; marks the current sample as channel 0.
- `dout`  output  8*W  last complete frame; channel k in bits `[k*W +: W]`; held between frames.
- `frame_valid`  output  1  one-cycle pulse when `dout` updates.
- `locked`  output  1  high while in state LOCKED.
- `ch_idx`  output  3  next channel slot expected (frame counter).
- `sync_err`  output  1  one-cycle pulse on an alignment violation.

## Operation
- Internal state:
  - `state` ∈ {HUNT, LOCKED}
  - 3-bit counter `cnt`, driven onto `ch_idx`
  - shadow registers `sh[0..6]`, W bits each
- Reset (`rst`=1 at a clock edge): state=HUNT, `cnt`=0, `sh`=0, `dout`=0, `frame_valid`=0, `locked`=0, `sync_err`=0. `rst` overrides all inputs in the same cycle.
- The block acts only on cycles where `din_valid`=1. With `din_valid`=0, all state holds and the pulses drop to 0. Gaps between samples are allowed, with no limit on length.
- HUNT:
  - Valid sample with `frame_sync`=1: `sh[0]`←`din`, `cnt`←1, go LOCKED.
  - Valid sample with `frame_sync`=0: dropped. No error, `cnt` stays 0.
- LOCKED, valid sample:
  - `frame_sync`=1 and `cnt`=0: normal channel 0. `sh[0]`←`din`, `cnt`←1.
  - `frame_sync`=1 and `cnt`≠0 (early sync): `sync_err` pulses. The partial frame is discarded, `sh[0]`←`din`, `cnt`←1, stay LOCKED, `dout` unchanged.
  - `frame_sync`=0 and `cnt`=0 (missing sync): `sync_err` pulses, sample dropped, go HUNT.
  - `frame_sync`=0 and 1≤`cnt`≤6: `sh[cnt]`←`din`, `cnt`←`cnt`+1.
  - `frame_sync`=0 and `cnt`=7: `dout`←{`din`, `sh[6]`, …, `sh[0]`}, `frame_valid` pulses, `cnt` wraps to 0.
- Stale `sh` contents from a discarded frame are never published, because every slot is rewritten before the next publish.
- `dout` updates only on frame completion. A partial frame never reaches `dout`.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- Latency: `dout` and `frame_valid` take effect on the same edge that samples channel 7. They are visible in the cycle following that edge, and `frame_valid` is high for exactly that cycle.
- Back-to-back frames at full rate (`din_valid` held high): `frame_valid` every 8 cycles.
- `sync_err` is high for exactly one cycle after the offending edge. It never coincides with `frame_valid`.
- `locked` rises the cycle after the first accepted sync and falls the cycle after a missing-sync event.
- `ch_idx` reflects `cnt` after the edge, i.e. the slot the next valid sample will fill.
- Reset mid-frame: the partial frame is lost and `dout` returns to 0. The next frame requires a fresh sync.

## Test plan
- **Basic frame (W=1):** after reset, stream ch0..ch7 = 1,1,0,0,1,1,0,1 with `frame_sync` on ch0 and `din_valid` held high.
  - Expect `dout`=8'hB3 and a single `frame_valid` pulse one cycle after the ch7 edge.
  - Expect `locked`=1 and `ch_idx`=0 afterwards.
- **Hunt discard and gaps:** send 3 valid samples without sync, then a frame 8'hD5 with random `din_valid` gaps.
  - Expect `locked`=0 and `ch_idx`=0 during the unsynced samples.
  - Expect `dout`=8'hD5 exactly once, with no `sync_err`.
- **Early sync:** after frame 8'hB3, send 4 samples, then assert sync and send a full frame 8'h0F.
  - Expect one `sync_err` pulse and `dout` held at 8'hB3 until the new frame completes.
  - Then expect `dout`=8'h0F with no intermediate `frame_valid`.
- **Missing sync:** after a good frame, send a channel-0 sample with `frame_sync`=0.
  - Expect a `sync_err` pulse and `locked`→0.
  - Subsequent samples are ignored until the next sync.
- **W=4, back-to-back:** two consecutive frames, channel k = k then channel k = 15−k.
  - Expect `dout`=32'h76543210 then 32'h89ABCDEF, with `frame_valid` exactly 8 cycles apart.
- **Reset mid-frame:** assert `rst` for 1 cycle after ch3 of a frame.
  - Expect all outputs 0 and state HUNT.
  - A following clean frame 8'hA5 publishes correctly.
